iz_param_bank_loader: RTL and testbench
=======================================

Name: iz_param_bank_loader

Overview:
- Serial loader for Izhikevich neuron parameters, generalised to NUM_CH neuron channels, NUM_PARAMS parameters of PARAM_W bits each.
- Each serial frame carries a channel address, the parameter payload and an even-parity bit.
- The payload is committed to the addressed channel's parameter bank atomically, and only on a valid frame. Invalid or aborted frames leave the banks unchanged.
- Sits between the chip input pins and the per-channel neuron cores.

Parameters:
- NUM_CH, 2, number of neuron channels (≥1).
- NUM_PARAMS, 4, parameters per channel (order a, b, c, d, ...).
- PARAM_W, 16, bits per parameter, signed Q8.8 in the default configuration.
- CH_W, 1, address bits in the frame header, ≥ max(1, clog2(NUM_CH)).
- DEFAULTS, {16'sd51, 16'sd51, -16'sd16640, 16'sd512}, flat reset vector for one channel. Parameter 0 occupies the MSBs. The vector is replicated to every channel.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, global clock-enable; when low, all state except the edge-detect register holds.
- load_enable, input, 1, frame strobe; a rising edge starts a frame, and the strobe must stay high for the whole frame.
- serial_data_in, input, 1, serial bit, MSB first.
- params_flat, output, NUM_CH*NUM_PARAMS*PARAM_W, active banks. Channel 0 occupies the LSB slice; within a channel, parameter 0 occupies the MSBs.
- params_ready, output, NUM_CH, per-channel flag; low while that channel is targeted by an in-flight frame.
- busy, output, 1, high whenever the state is not IDLE.
- frame_done, output, 1, one-cycle pulse on a successful commit.
- frame_error, output, 1, one-cycle pulse on a parity error, bad address, or abort.

Behaviour:
- **Reset.** All banks load DEFAULTS. params_ready is all ones; busy, frame_done and frame_error are 0; state is IDLE; counters and shift register are 0.
- **Edge detect.** load_enable_prev is registered every cycle, regardless of enable. A start is recognised only when rise = load_enable & ~load_enable_prev & enable.
- **Sampling.** Bits are sampled only on cycles with enable=1 and load_enable=1, and never on the start cycle itself.
- **States:**
  - IDLE: on rise, go to ADDR; clear bit_cnt, shift register and parity accumulator.
  - ADDR: shift CH_W bits into addr_reg. After the last address bit, go to DATA. Also drive params_ready[addr]=0 if addr<NUM_CH (effective the cycle after the last address bit).
  - DATA: shift NUM_PARAMS*PARAM_W bits into a shadow register. After the last bit, go to PARITY.
  - PARITY: sample one bit. Check that the XOR of all address, data and parity bits equals 0, and that addr<NUM_CH.
    - Pass: copy the shadow into bank[addr] in the same cycle the next state is entered; frame_done=1 for one cycle.
    - Fail: banks untouched; frame_error=1 for one cycle.
    - In both cases, restore params_ready[addr] and go to WAIT.
  - WAIT: stay until load_enable=0, then go to IDLE. A new rise is only possible after a low cycle, so back-to-back frames need at least one low cycle.
- **Latency.** With enable held high, the bank updates on the clock edge that samples the parity bit. Frame length is CH_W + NUM_PARAMS*PARAM_W + 1 sampled bits after the start cycle.
- **Abort.** load_enable=0 with enable=1 while in ADDR, DATA or PARITY:
  - frame_error pulses;
  - params_ready is restored to all ones;
  - go to IDLE;
  - no bank changes.
- **enable=0 mid-frame.** Everything freezes: no sample is taken and no abort is detected. The frame resumes when enable returns.
- **Other channels.** Banks of non-addressed channels never change. Their params_ready stays 1 throughout.
- **Reset mid-frame.** reset wins over everything in the same cycle. All banks return to DEFAULTS, including any already loaded by earlier frames.
- **Pulse exclusivity.** frame_done and frame_error are never high in the same cycle.
- **Bank output.** params_flat is driven directly from the bank registers, with no combinational path from serial_data_in.

Test Plan:
1. **Reset defaults.** Assert reset for 2 cycles → every channel reads a=51, b=51, c=-16640, d=512; params_ready=2'b11; busy=0.
2. **Valid frame to ch1.** Send addr=1, a=100, b=200, c=-16000, d=1024, with parity making the total XOR 0 → frame_done pulses once, 66 samples after the start cycle. ch1 holds the new values; ch0 is unchanged. params_ready[1] is low during DATA and PARITY; params_ready[0] stays 1.
3. **Parity error.** Send the same frame to ch0 with the parity bit inverted → frame_error pulses; ch0 keeps its defaults; frame_done stays 0.
4. **Abort.** Drop load_enable after 20 data bits → frame_error next cycle; busy=0; params_ready=2'b11; banks unchanged. A new valid frame immediately after then commits correctly.
5. **Enable stall.** Deassert enable for 5 cycles mid-DATA while load_enable stays high → no bits are lost; the committed values are identical to scenario 2.
6. **Reset mid-frame and bad address.** Pulse reset during DATA of a ch1 frame → ch1 holds defaults and state is IDLE. Then, with NUM_CH=3 and CH_W=2, send addr=3 → frame_error pulses and no bank changes.

Source files
------------

// File: rtl/iz_param_bank_loader.sv
// Serial loader for per-channel Izhikevich neuron parameter banks.
// A frame is {address, payload, even parity}, MSB first, and commits atomically on success.
module iz_param_bank_loader #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned NUM_PARAMS = 4,
    parameter int unsigned PARAM_W    = 16,
    parameter int unsigned CH_W       = 1,
    parameter logic [NUM_PARAMS*PARAM_W-1:0] DEFAULTS =
        {16'sd51, 16'sd51, -16'sd16640, 16'sd512}
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                load_enable,
    input  logic                                serial_data_in,
    output logic [NUM_CH*NUM_PARAMS*PARAM_W-1:0] params_flat,
    output logic [NUM_CH-1:0]                   params_ready,
    output logic                                busy,
    output logic                                frame_done,
    output logic                                frame_error
);

    localparam int unsigned DATA_W = NUM_PARAMS * PARAM_W;
    localparam int unsigned CNT_W  = $clog2(DATA_W + CH_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_PARITY,
        S_WAIT
    } state_t;

    state_t              state, state_n;
    logic                le_prev;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [CH_W-1:0]     addr_reg, addr_n;
    logic [DATA_W-1:0]   shadow, shadow_n;
    logic                parity_acc, parity_n;
    logic [NUM_CH-1:0]   ready_n;
    logic                busy_n, done_n, error_n, commit;
    logic [DATA_W-1:0]   bank [NUM_CH];

    logic rise, sample, abort, in_frame, addr_ok, parity_ok;

    assign rise      = load_enable & ~le_prev & enable;
    assign sample    = enable & load_enable;
    assign abort     = enable & ~load_enable;
    assign in_frame  = (state == S_ADDR) || (state == S_DATA) || (state == S_PARITY);
    assign addr_ok   = 32'(addr_reg) < NUM_CH;
    assign parity_ok = ~(parity_acc ^ serial_data_in);

    // Next-state and datapath control
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        addr_n    = addr_reg;
        shadow_n  = shadow;
        parity_n  = parity_acc;
        ready_n   = params_ready;
        done_n    = 1'b0;
        error_n   = 1'b0;
        commit    = 1'b0;

        if (in_frame && abort) begin
            state_n = S_IDLE;
            ready_n = '1;
            error_n = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state_n   = S_ADDR;
                        bit_cnt_n = '0;
                        addr_n    = '0;
                        shadow_n  = '0;
                        parity_n  = 1'b0;
                    end
                end
                S_ADDR: begin
                    if (sample) begin
                        addr_n   = CH_W'({addr_reg, serial_data_in});
                        parity_n = parity_acc ^ serial_data_in;
                        if (bit_cnt == CNT_W'(CH_W - 1)) begin
                            bit_cnt_n = '0;
                            state_n   = S_DATA;
                            for (int unsigned c = 0; c < NUM_CH; c++) begin
                                if (32'(addr_n) == c) ready_n[c] = 1'b0;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        shadow_n = DATA_W'({shadow, serial_data_in});
                        parity_n = parity_acc ^ serial_data_in;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_n = '0;
                            state_n   = S_PARITY;
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (sample) begin
                        state_n  = S_WAIT;
                        ready_n  = '1;
                        parity_n = parity_acc ^ serial_data_in;
                        if (parity_ok && addr_ok) begin
                            commit = 1'b1;
                            done_n = 1'b1;
                        end else begin
                            error_n = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (abort) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end

        busy_n = (state_n != S_IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Datapath, banks and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            le_prev      <= 1'b0;
            bit_cnt      <= '0;
            addr_reg     <= '0;
            shadow       <= '0;
            parity_acc   <= 1'b0;
            params_ready <= '1;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) bank[c] <= DEFAULTS;
        end else begin
            le_prev      <= load_enable;
            bit_cnt      <= bit_cnt_n;
            addr_reg     <= addr_n;
            shadow       <= shadow_n;
            parity_acc   <= parity_n;
            params_ready <= ready_n;
            busy         <= busy_n;
            frame_done   <= done_n;
            frame_error  <= error_n;
            if (commit) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (32'(addr_reg) == c) bank[c] <= shadow;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign params_flat[g*DATA_W +: DATA_W] = bank[g];
    end

endmodule

// File: tb/tb_iz_param_bank_loader.sv
// Bench for iz_param_bank_loader: vector table plus scoreboard of expected frame outcomes.
module tb_iz_param_bank_loader;

    localparam logic [63:0] DEF = 64'h0033_0033_BF00_0200;
    localparam logic [63:0] D2  = 64'h0064_00C8_C180_0400;

    logic clk = 1'b0;
    logic reset, enable, load_enable, serial, sel3;

    logic [127:0] flat0;
    logic [1:0]   rdy0;
    logic         busy0, done0, err0;
    logic [191:0] flat3;
    logic [2:0]   rdy3;
    logic         busy3, done3, err3;

    iz_param_bank_loader dut (
        .clk(clk), .reset(reset), .enable(enable),
        .load_enable(load_enable && !sel3), .serial_data_in(serial),
        .params_flat(flat0), .params_ready(rdy0), .busy(busy0),
        .frame_done(done0), .frame_error(err0)
    );

    iz_param_bank_loader #(.NUM_CH(3), .CH_W(2)) dut3 (
        .clk(clk), .reset(reset), .enable(enable),
        .load_enable(load_enable && sel3), .serial_data_in(serial),
        .params_flat(flat3), .params_ready(rdy3), .busy(busy3),
        .frame_done(done3), .frame_error(err3)
    );

    always #5 clk = ~clk;

    logic [191:0] m_flat;
    logic [2:0]   m_rdy;
    logic         m_busy, m_done, m_err;
    assign m_flat = sel3 ? flat3 : {64'b0, flat0};
    assign m_rdy  = sel3 ? rdy3  : {1'b1, rdy0};
    assign m_busy = sel3 ? busy3 : busy0;
    assign m_done = sel3 ? done3 : done0;
    assign m_err  = sel3 ? err3  : err0;

    typedef struct {
        logic         done;
        logic         err;
        logic [191:0] flat;
        int           lat;
    } exp_t;

    typedef struct {
        logic [1:0]  addr;
        logic [63:0] data;
        bit          bad;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    exp_t        sb[$];
    logic [63:0] model [3];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [191:0] act, logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [191:0] exp_flat();
        return sel3 ? {model[2], model[1], model[0]} : {64'b0, model[1], model[0]};
    endfunction

    // Every done/error pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (m_done || m_err) begin
            chk("pulse_exclusive", 192'(m_done & m_err), 192'(0));
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", m_done, m_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_done", 192'(m_done), 192'(e.done));
                chk("pulse_err", 192'(m_err), 192'(e.err));
                chk("bank_after_frame", m_flat, e.flat);
                if (e.lat != 0) chk("frame_latency", 192'(cyc - start_cyc), 192'(e.lat));
            end
        end
    end

    task automatic drive_frame(input int chw, input logic [1:0] addr, input logic [63:0] data,
                               input bit bad, input bit exp_done, input bit exp_err,
                               input int abort_at, input int stall_at, input int reset_at);
        bit          bq[$];
        bit          p;
        int          total;
        bit          valid;
        logic [2:0]  exp_rdy;
        exp_t        e;
        p = 1'b0;
        for (int k = chw - 1; k >= 0; k--) bq.push_back(addr[k]);
        for (int k = 63; k >= 0; k--) bq.push_back(data[k]);
        foreach (bq[k]) p ^= bq[k];
        bq.push_back(p ^ bad);
        total   = chw + 65;
        valid   = 32'(addr) < (sel3 ? 32'd3 : 32'd2);
        exp_rdy = 3'b111 & ~(valid ? (3'b001 << addr) : 3'b000);
        if (exp_done || exp_err) begin
            if (exp_done) model[addr] = data;
            e.done = exp_done;
            e.err  = exp_err;
            e.flat = exp_flat();
            e.lat  = (abort_at < 0 && stall_at < 0) ? total : 0;
            sb.push_back(e);
        end
        @(negedge clk);
        load_enable = 1'b1;
        serial      = 1'b0;
        start_cyc   = cyc + 1;
        for (int i = 0; i < total; i++) begin
            if (i == reset_at) begin
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset       = 1'b0;
                load_enable = 1'b0;
                for (int k = 0; k < 3; k++) model[k] = DEF;
                return;
            end
            if (i == abort_at) begin
                @(negedge clk);
                load_enable = 1'b0;
                @(negedge clk);
                chk("abort_busy", 192'(m_busy), 192'(0));
                chk("abort_ready", 192'(m_rdy), 192'(3'b111));
                return;
            end
            if (i == stall_at) begin
                @(negedge clk);
                enable = 1'b0;
                serial = ~bq[i];
                repeat (4) @(negedge clk);
                chk("stall_busy", 192'(m_busy), 192'(1));
            end
            @(negedge clk);
            enable = 1'b1;
            serial = bq[i];
            if (i == 0) chk("ready_before_addr", 192'(m_rdy), 192'(3'b111));
            if (i == chw + 10 || i == total - 1) chk("ready_in_frame", 192'(m_rdy), 192'(exp_rdy));
        end
        @(negedge clk);
        load_enable = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{2'd1, D2, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{2'd0, D2, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{2'd0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{2'd1, 64'hFFFF_0000_8000_7FFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{2'd0, 64'h0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) model[k] = DEF;

        reset = 1'b1; enable = 1'b1; load_enable = 1'b0; serial = 1'b0; sel3 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_banks", m_flat, {64'b0, DEF, DEF});
        chk("reset_banks_3ch", flat3, {DEF, DEF, DEF});
        chk("reset_ready", 192'(rdy0), 192'(2'b11));
        chk("reset_busy", 192'(busy0), 192'(0));
        chk("reset_pulses", 192'({done0, err0}), 192'(0));

        foreach (vecs[v])
            drive_frame(1, vecs[v].addr, vecs[v].data, vecs[v].bad,
                        vecs[v].exp_done, vecs[v].exp_err, -1, -1, -1);

        // Abort after 20 data bits, then an immediate good frame
        drive_frame(1, 2'd0, D2, 1'b0, 1'b0, 1'b1, 21, -1, -1);
        drive_frame(1, 2'd0, D2, 1'b0, 1'b1, 1'b0, -1, -1, -1);

        // Enable stall in the middle of the payload
        drive_frame(1, 2'd1, D2, 1'b0, 1'b1, 1'b0, -1, 31, -1);
        @(negedge clk);
        chk("stall_ch1_value", 192'(flat0[127:64]), 192'(D2));

        // Reset mid-frame returns every bank to defaults
        drive_frame(1, 2'd1, 64'hAAAA_5555_AAAA_5555, 1'b0, 1'b0, 1'b0, -1, -1, 31);
        chk("midreset_busy", 192'(busy0), 192'(0));
        chk("midreset_banks", 192'(flat0), 192'({DEF, DEF}));
        chk("midreset_ready", 192'(rdy0), 192'(2'b11));

        // Three-channel instance: out-of-range address, then a good frame to ch2
        @(negedge clk);
        sel3 = 1'b1;
        drive_frame(2, 2'd3, D2, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        drive_frame(2, 2'd2, D2, 1'b0, 1'b1, 1'b0, -1, -1, -1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 192'(sb.size()), 192'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
